// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, FSM state
// encoding and opcode width.
// No ports; imported by seq_alu and seq_alu_muldiv.
package seq_alu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADDU = 4'd0,
    OP_ADDS = 4'd1,
    OP_SUBU = 4'd2,
    OP_SUBS = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SHR1 = 4'd7,
    OP_MULU = 4'd8,
    OP_DIVU = 4'd9
  } opcode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Multiply and divide take the multi-cycle path through the muldiv unit.
  function automatic logic is_iterative(input logic [OPCODE_W-1:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per
// cycle for exactly NUMBITS cycles after start.
// Ports: clk/reset; start+op(0=mul,1=div)+A+B load operands; done pulses on the
// last iteration with result/hi_nonzero valid in that same cycle.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int NUMBITS = 8,
  localparam int CNT_W  = $clog2(NUMBITS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  output logic               done,
  output logic [NUMBITS-1:0] result,
  output logic               hi_nonzero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUMBITS - 1);

  logic               busy;
  logic               is_div;
  logic [CNT_W-1:0]   cnt;
  logic [NUMBITS-1:0] opnd;   // multiplicand or divisor
  logic [NUMBITS-1:0] hi;     // product high half / partial remainder
  logic [NUMBITS-1:0] lo;     // multiplier bits / dividend-then-quotient
  logic [NUMBITS-1:0] hi_nxt;
  logic [NUMBITS-1:0] lo_nxt;
  logic [NUMBITS:0]   mul_sum;
  logic [NUMBITS:0]   div_shift;
  logic [NUMBITS:0]   div_diff;
  logic               div_ge;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[NUMBITS-1]};
    div_diff  = div_shift - {1'b0, opnd};
    // Partial remainder is always below 2*divisor, so bit NUMBITS of the
    // difference is a clean borrow indicator.
    div_ge    = ~div_diff[NUMBITS];
    if (is_div) begin
      hi_nxt = div_ge ? div_diff[NUMBITS-1:0] : div_shift[NUMBITS-1:0];
      lo_nxt = {lo[NUMBITS-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[NUMBITS:1];
      lo_nxt = {mul_sum[0], lo[NUMBITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      is_div <= op;
      cnt    <= '0;
      opnd   <= op ? B : A;
      hi     <= '0;
      lo     <= op ? A : B;
    end else if (busy) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Outputs reflect the post-step values so the caller can latch them on the
  // same edge as the final iteration. Divide by zero naturally yields an
  // all-ones quotient from the restoring loop.
  assign done       = busy && (cnt == LAST);
  assign result     = lo_nxt;
  assign hi_nonzero = is_div ? (opnd == '0) : (hi_nxt != '0);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle ops
// complete one cycle after acceptance; MULU/DIVU take NUMBITS+1 cycles.
// Ports: clk, reset (async high); A/B/opcode with in_valid/in_ready; registered
// result, carryout, overflow, zero with out_valid/out_ready.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int NUMBITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUMBITS-1:0]  A,
  input  logic [NUMBITS-1:0]  B,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUMBITS-1:0]  result,
  output logic                carryout,
  output logic                overflow,
  output logic                zero,
  output logic                out_valid,
  input  logic                out_ready
);

  if (NUMBITS < 4) begin : g_width_check
    $error("seq_alu: NUMBITS must be at least 4");
  end

  localparam int MSB = NUMBITS - 1;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               accept;
  logic               go_iter;
  logic               md_done;
  logic               md_hi_nz;
  logic [NUMBITS-1:0] md_result;
  logic [NUMBITS-1:0] alu_res;
  logic               alu_c;
  logic               alu_o;
  logic [NUMBITS:0]   add_ext;
  logic [NUMBITS:0]   sub_ext;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign go_iter   = is_iterative(opcode);
  assign out_valid = (state == ST_DONE);

  // Single-cycle datapath evaluated on the operands being accepted; its
  // outputs are registered on the acceptance edge, so later input changes
  // have no effect.
  always_comb begin
    add_ext = {1'b0, A} + {1'b0, B};
    sub_ext = {1'b0, A} - {1'b0, B};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (opcode)
      OP_ADDU: begin
        alu_res = add_ext[MSB:0];
        alu_c   = add_ext[NUMBITS];
      end
      OP_ADDS: begin
        alu_res = add_ext[MSB:0];
        alu_o   = (A[MSB] == B[MSB]) && (add_ext[MSB] != A[MSB]);
      end
      OP_SUBU: begin
        alu_res = sub_ext[MSB:0];
        alu_c   = sub_ext[NUMBITS];   // borrow: A < B
      end
      OP_SUBS: begin
        alu_res = sub_ext[MSB:0];
        alu_o   = (A[MSB] != B[MSB]) && (sub_ext[MSB] != A[MSB]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SHR1: alu_res = {1'b0, A[MSB:1]};
      default: alu_res = '0;          // reserved opcodes
    endcase
  end

  seq_alu_muldiv #(.NUMBITS(NUMBITS)) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .start      (accept && go_iter),
    .op         (opcode == OP_DIVU),
    .A          (A),
    .B          (B),
    .done       (md_done),
    .result     (md_result),
    .hi_nonzero (md_hi_nz)
  );

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = go_iter ? ST_BUSY : ST_DONE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_BUSY: if (md_done) state_nxt = ST_DONE;
        ST_DONE: if (out_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && !go_iter) begin
        result   <= alu_res;
        carryout <= alu_c;
        overflow <= alu_o;
        zero     <= (alu_res == '0);
      end else if ((state == ST_BUSY) && md_done) begin
        result   <= md_result;
        carryout <= 1'b0;
        overflow <= md_hi_nz;
        zero     <= (md_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    longint unsigned res;
    bit              c;
    bit              o;
    bit              z;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        out_ready = 1'b1;
  logic [3:0]  opcode = 4'd0;
  logic        iv8 = 1'b0, iv16 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;

  logic        rdy8, ov8, c8, o8, z8;
  logic [7:0]  r8;
  logic        rdy16, ov16, c16, o16, z16;
  logic [15:0] r16;

  always #5 clk = ~clk;

  seq_alu #(.NUMBITS(8)) dut8 (
    .clk(clk), .reset(reset), .A(a8), .B(b8), .opcode(opcode),
    .in_valid(iv8), .in_ready(rdy8), .result(r8), .carryout(c8),
    .overflow(o8), .zero(z8), .out_valid(ov8), .out_ready(out_ready)
  );

  seq_alu #(.NUMBITS(16)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .opcode(opcode),
    .in_valid(iv16), .in_ready(rdy16), .result(r16), .carryout(c16),
    .overflow(o16), .zero(z16), .out_valid(ov16), .out_ready(out_ready)
  );

  // Reference model in wide integer arithmetic.
  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input longint unsigned a, input longint unsigned b);
    exp_t e;
    longint unsigned mask, p;
    longint sa, sbv, s, smax, smin;
    mask = (64'd1 << w) - 64'd1;
    smax = longint'((64'd1 << (w - 1)) - 64'd1);
    smin = -longint'(64'd1 << (w - 1));
    sa   = (a > longint'(smax)) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sbv  = (b > longint'(smax)) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    e.res = 0; e.c = 0; e.o = 0;
    case (op)
      4'd0: begin p = a + b; e.res = p & mask; e.c = (p >> w) != 0; end
      4'd1: begin s = sa + sbv; e.res = longint'(s) & mask; e.o = (s > smax) || (s < smin); end
      4'd2: begin e.res = (a - b) & mask; e.c = (a < b); end
      4'd3: begin s = sa - sbv; e.res = longint'(s) & mask; e.o = (s > smax) || (s < smin); end
      4'd4: e.res = a & b;
      4'd5: e.res = a | b;
      4'd6: e.res = a ^ b;
      4'd7: e.res = a >> 1;
      4'd8: begin p = a * b; e.res = p & mask; e.o = (p >> w) != 0; end
      4'd9: begin
        if (b == 0) begin e.res = mask; e.o = 1; end
        else e.res = a / b;
      end
      default: e.res = 0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Issue one operation, wait for its result, compare latency and outputs.
  task automatic run_op(input bit w16, input logic [3:0] op,
                        input longint unsigned a, input longint unsigned b,
                        input int exp_lat, input string nm, input bit chk_busy);
    exp_t e;
    int lat;
    bit seen, rdy_bad;
    logic [15:0] gr;
    logic gc, go, gz, grdy;
    e = model(w16 ? 16 : 8, op, a, b);
    sb_q.push_back(e);
    @(posedge clk); #1;
    opcode = op;
    if (w16) begin a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1; end
    else     begin a8  = a[7:0];  b8  = b[7:0];  iv8  = 1'b1; end
    @(negedge clk);
    grdy = w16 ? rdy16 : rdy8;
    total++;
    if (grdy !== 1'b1) begin
      bad++; $display("FAIL %s idle_ready got=%b want=1", nm, grdy);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; iv16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    opcode = 4'($urandom);
    lat = 0; seen = 0; rdy_bad = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if ((w16 ? ov16 : ov8) === 1'b1) begin seen = 1; lat = i; end
      else if ((w16 ? rdy16 : rdy8) !== 1'b0) rdy_bad = 1;
    end
    total++;
    if (!seen || lat != exp_lat) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d (seen=%0b)", nm, lat, exp_lat, seen);
    end
    if (chk_busy) begin
      total++;
      if (rdy_bad) begin bad++; $display("FAIL %s busy_ready got=1 want=0", nm); end
    end
    e = sb_q.pop_front();
    if (seen) begin
      gr = w16 ? r16 : {8'h00, r8};
      gc = w16 ? c16 : c8;
      go = w16 ? o16 : o8;
      gz = w16 ? z16 : z8;
      total++;
      if (gr !== 16'(e.res) || gc !== e.c || go !== e.o || gz !== e.z) begin
        bad++;
        $display("FAIL %s result got=%h c=%b o=%b z=%b want=%h c=%b o=%b z=%b",
                 nm, gr, gc, go, gz, 16'(e.res), e.c, e.o, e.z);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (ov8 !== 1'b0 || r8 !== 8'h00 || c8 !== 1'b0 || o8 !== 1'b0 || z8 !== 1'b0 ||
        ov16 !== 1'b0 || r16 !== 16'h0000) begin
      bad++;
      $display("FAIL reset_outputs got ov=%b r=%h c=%b o=%b z=%b r16=%h want all 0",
               ov8, r8, c8, o8, z8, r16);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    total++;
    if (rdy8 !== 1'b1 || rdy16 !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b/%b want=1/1", rdy8, rdy16);
    end
  endtask

  task automatic test_single_cycle();
    run_op(0, OP_ADDU, 'hFF, 'h01, 1, "addu_ff_01", 0);
    run_op(0, OP_ADDS, 'h7F, 'h01, 1, "adds_ovf", 0);
    run_op(0, OP_SUBS, 'hC0, 'h40, 1, "subs_c0_40", 0);
    run_op(0, OP_SUBS, 'hC0, 'h41, 1, "subs_c0_41", 0);
    run_op(0, OP_SUBU, 'h01, 'h02, 1, "subu_borrow", 0);
    run_op(0, OP_AND,  'h3C, 'hA5, 1, "and", 0);
    run_op(0, OP_OR,   'h30, 'h05, 1, "or", 0);
    run_op(0, OP_SHR1, 'h81, 'hFF, 1, "shr1", 0);
    run_op(0, 4'd12,   'h12, 'h34, 1, "reserved", 0);
  endtask

  task automatic test_muldiv();
    run_op(0, OP_MULU, 'h10, 'h10, 9, "mulu_10_10", 1);
    run_op(0, OP_MULU, 'h0F, 'h03, 9, "mulu_0f_03", 1);
    run_op(0, OP_DIVU, 'hFF, 'h10, 9, "divu_ff_10", 1);
    run_op(0, OP_DIVU, 'h55, 'h00, 9, "divu_by_zero", 1);
    run_op(0, OP_DIVU, 'h64, 'h07, 9, "divu_64_07", 1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    @(posedge clk); #1;
    opcode = OP_ADDU; a8 = 8'hFF; b8 = 8'h01; iv8 = 1'b1;
    sb_q.push_back(model(8, OP_ADDU, 'hFF, 'h01));
    @(posedge clk); #1;
    opcode = OP_XOR; a8 = 8'h0F; b8 = 8'hF0;
    sb_q.push_back(model(8, OP_XOR, 'h0F, 'hF0));
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if (ov8 !== 1'b1 || r8 !== 8'(e.res) || rdy8 !== 1'b1) begin
      bad++; $display("FAIL b2b_first got ov=%b r=%h rdy=%b want ov=1 r=%h rdy=1", ov8, r8, rdy8, 8'(e.res));
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    total++;
    if (ov8 !== 1'b1 || r8 !== 8'(e.res)) begin
      bad++; $display("FAIL b2b_second got ov=%b r=%h want ov=1 r=%h", ov8, r8, 8'(e.res));
    end
    // Stall the output for three cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    opcode = OP_AND; a8 = 8'h3C; b8 = 8'h0F; iv8 = 1'b1;
    sb_q.push_back(model(8, OP_AND, 'h3C, 'h0F));
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); opcode = OP_XOR;
    e = sb_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ov8 !== 1'b1 || r8 !== 8'(e.res) || z8 !== e.z || rdy8 !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d got ov=%b r=%h z=%b rdy=%b want ov=1 r=%h z=%b rdy=0",
                 i, ov8, r8, z8, rdy8, 8'(e.res), e.z);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (ov8 !== 1'b1 || rdy8 !== 1'b1) begin
      bad++; $display("FAIL hold_release got ov=%b rdy=%b want 1/1", ov8, rdy8);
    end
    @(negedge clk);
    total++;
    if (ov8 !== 1'b0) begin
      bad++; $display("FAIL hold_idle got ov=%b want 0", ov8);
    end
  endtask

  task automatic test_reset_abort();
    bit rose;
    @(posedge clk); #1;
    opcode = OP_DIVU; a8 = 8'hFF; b8 = 8'h03; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if (ov8 !== 1'b0 || r8 !== 8'h00 || c8 !== 1'b0 || o8 !== 1'b0 || z8 !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs got ov=%b r=%h c=%b o=%b z=%b want all 0", ov8, r8, c8, o8, z8);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (rdy8 !== 1'b1) begin
      bad++; $display("FAIL abort_ready got=%b want=1", rdy8);
    end
    rose = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov8 !== 1'b0) rose = 1;
    end
    total++;
    if (rose) begin
      bad++; $display("FAIL abort_no_result got out_valid=1 want 0");
    end
  endtask

  task automatic test_wide();
    run_op(1, OP_MULU, 'h0010, 'h0010, 17, "mulu16_10_10", 1);
    run_op(1, OP_MULU, 'h0100, 'h0100, 17, "mulu16_ovf", 1);
    run_op(1, OP_MULU, 'h000F, 'h0003, 17, "mulu16_0f_03", 1);
    run_op(1, OP_DIVU, 'hFFFF, 'h0010, 17, "divu16", 1);
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter NUMBITS, default 8, operand/result width; SHALL be >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 A  input  NUMBITS  operand A.
REQ-005 B  input  NUMBITS  operand B; ignored for SHR1.
REQ-006 opcode  input  4  operation select (REQ-012).
REQ-007 in_valid  input  1  A/B/opcode valid.
REQ-008 in_ready  output  1  block accepts an operation this cycle.
REQ-009 result  output  NUMBITS  registered result.
REQ-010 carryout, overflow, zero  output  1 each  registered flags.
REQ-011 out_valid  output  1 and out_ready  input  1  result handshake.

Function
REQ-012 Opcodes SHALL be: 0 ADDU, 1 ADDS, 2 SUBU, 3 SUBS, 4 AND, 5 OR, 6 XOR, 7 SHR1 (logical A>>1), 8 MULU (low NUMBITS of A*B), 9 DIVU (A/B quotient); 10-15 reserved.
REQ-013 An operation SHALL be accepted only on a cycle with in_valid && in_ready; operands and opcode SHALL be captured on acceptance and later input changes ignored.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; state after reset is IDLE.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, 0 otherwise (BUSY always 0).
REQ-016 Opcodes 0-7 and 10-15 SHALL go to DONE one cycle after acceptance (latency 1).
REQ-017 MULU/DIVU SHALL go to BUSY, iterate exactly NUMBITS cycles (shift-add / restoring), then enter DONE (latency NUMBITS+1).
REQ-018 In DONE out_valid SHALL be 1 and result/flags SHALL be held stable until out_ready=1.
REQ-019 DONE with out_ready=1 and in_valid=1 SHALL accept the new operation in the same cycle (back-to-back, no bubble); with in_valid=0 go to IDLE.
REQ-020 zero SHALL equal (result == 0) for every opcode.
REQ-021 carryout SHALL be: ADDU carry out of bit NUMBITS-1; SUBU borrow (1 iff A<B unsigned); 0 for all other opcodes.
REQ-022 overflow SHALL be: ADDS/SUBS two's-complement signed overflow; MULU 1 iff upper NUMBITS of product nonzero; DIVU 1 iff B=0; 0 otherwise.
REQ-023 DIVU with B=0 SHALL return result all-ones, in the same NUMBITS+1 latency.
REQ-024 Reserved opcodes SHALL return result 0, zero=1, carryout=0, overflow=0.
REQ-025 out_valid SHALL be 0 in IDLE and BUSY.

Reset
REQ-026 Reset asserted SHALL immediately force IDLE, result=0, carryout=0, overflow=0, zero=0, out_valid=0, iteration counter=0.
REQ-027 Reset during BUSY or DONE SHALL abort the operation; no result SHALL be presented after reset release.
REQ-028 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-029 Package seq_alu_pkg SHALL hold the opcode enumeration, FSM state enumeration and opcode width constant.
REQ-030 Iterative multiply/divide SHALL be a sub-module seq_alu_muldiv (start, op, A, B -> done, result, hi_nonzero) with counter width clog2(NUMBITS+1).
REQ-031 Single-cycle ops SHALL be computed combinationally from captured operands in the top level and registered on entry to DONE.

Verification
REQ-032 NUMBITS=8, ADDU A=FF B=01, out_ready=1 -> out_valid 1 cycle after accept, result=00, zero=1, carryout=1.
REQ-033 SUBS A=C0(-64) B=40 -> result=80, overflow=0; A=C0 B=41 -> result=7F, overflow=1; SUBU A=01 B=02 -> result=FF, carryout=1.
REQ-034 MULU A=10 B=10 -> out_valid exactly 9 cycles after accept, result=00, overflow=1, zero=1; A=0F B=03 -> 2D, overflow=0.
REQ-035 DIVU A=FF B=10 -> result=0F; DIVU A=55 B=00 -> result=FF, overflow=1; in_ready=0 throughout BUSY.
REQ-036 Back-to-back: ADDU then XOR(0F,F0) with out_ready=1 -> two consecutive out_valid cycles, results then FF; hold out_ready=0 for 3 cycles -> result stable, in_ready=0.
REQ-037 Assert reset 4 cycles into a DIVU -> outputs 0 immediately, out_valid never rises for it, in_ready=1 after release; NUMBITS=16 rerun of REQ-034 with 17-cycle latency.
